// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined WIDTH x WIDTH -> 2*WIDTH Wallace-tree multiplier.
//   S1 registers the operands, S2 reduces the partial products to two rows,
//   S3 adds the two rows into prod. Valid/ready handshake with full-pipe stall.
// Optional feature macro: WALLACE_SIGNED_EN adds the 'sgn' port and
//   Baugh-Wooley two's-complement mode (same tree, same latency).
module wallace_mult_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef WALLACE_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [1:0]         occ
);

  localparam int PW     = 2 * WIDTH;
  localparam int STAGES = 3;
  // Column height never exceeds WIDTH+1 (signed correction bit on top of WIDTH terms).
  localparam int MAXH   = WIDTH + 2;
  // 17 rows reduce to 2 in 6 levels; the spare levels are skipped once heights are <= 2.
  localparam int NLEV   = 8;

  logic               stall, adv;
  logic [STAGES:0]    vld_pipe;
  logic [STAGES-1:0]  vld_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_in, sgn_q;
  logic [PW-1:0]      r0_d, r1_d, r0_q, r1_q;
  logic [PW-1:0]      prod_d, prod_q;

`ifdef WALLACE_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // Builds the partial-product matrix column by column and compresses it with
  // full adders (3:2) and half adders (2:2) per column until every column holds
  // at most two bits. Carries out of the top column are dropped: the result is
  // taken modulo 2^PW, which is exact for both unsigned and Baugh-Wooley forms.
  function automatic logic [2*PW-1:0] wallace_rows(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic             s);
    logic [MAXH-1:0] col [PW];
    logic [MAXH-1:0] nxt [PW];
    int              cnt [PW];
    int              ncnt[PW];
    int              hmax;
    logic            pp, s0, s1, s2;
    logic [PW-1:0]   row0, row1;
    for (int c = 0; c < PW; c++) begin
      col[c] = '0;
      cnt[c] = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = x[j] & y[i];
        // Baugh-Wooley: invert terms pairing exactly one sign bit with a magnitude bit.
        if (s && ((i == WIDTH-1) != (j == WIDTH-1))) pp = ~pp;
        col[i+j][cnt[i+j]] = pp;
        cnt[i+j]++;
      end
    end
    // Baugh-Wooley +1 corrections at columns WIDTH and 2*WIDTH-1.
    if (s) begin
      col[WIDTH][cnt[WIDTH]] = 1'b1;
      cnt[WIDTH]++;
      col[PW-1][cnt[PW-1]] = 1'b1;
      cnt[PW-1]++;
    end
    for (int lev = 0; lev < NLEV; lev++) begin
      hmax = 0;
      for (int c = 0; c < PW; c++) if (cnt[c] > hmax) hmax = cnt[c];
      if (hmax > 2) begin
        for (int c = 0; c < PW; c++) begin
          nxt[c]  = '0;
          ncnt[c] = 0;
        end
        for (int c = 0; c < PW; c++) begin
          for (int k = 0; k < MAXH; k += 3) begin
            if (k + 2 < cnt[c]) begin
              s0 = col[c][k];
              s1 = col[c][k+1];
              s2 = col[c][k+2];
              nxt[c][ncnt[c]] = s0 ^ s1 ^ s2;
              ncnt[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = (s0 & s1) | (s0 & s2) | (s1 & s2);
                ncnt[c+1]++;
              end
            end else if (k + 1 < cnt[c]) begin
              s0 = col[c][k];
              s1 = col[c][k+1];
              nxt[c][ncnt[c]] = s0 ^ s1;
              ncnt[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = s0 & s1;
                ncnt[c+1]++;
              end
            end else if (k < cnt[c]) begin
              nxt[c][ncnt[c]] = col[c][k];
              ncnt[c]++;
            end
          end
        end
        for (int c = 0; c < PW; c++) begin
          col[c] = nxt[c];
          cnt[c] = ncnt[c];
        end
      end
    end
    for (int c = 0; c < PW; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    return {row1, row0};
  endfunction

  // Handshake: whole pipe freezes when the result is held or ena is low.
  assign stall     = (vld_q[STAGES-1] && !out_ready) || !ena;
  assign adv       = !stall;
  assign in_ready  = ena && !(vld_q[STAGES-1] && !out_ready);
  assign vld_pipe  = {vld_q, in_valid && in_ready};
  assign out_valid = vld_pipe[STAGES];
  assign prod      = prod_q;
  assign occ       = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};

  // S2 combinational tree and S3 carry-propagate add.
  always_comb begin
    {r1_d, r0_d} = wallace_rows(a_q, b_q, sgn_q);
    prod_d       = r0_q + r1_q;
  end

  // Valid shift register; bubbles move with the data, never collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Data stages advance in lock-step with the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      r0_q   <= '0;
      r1_q   <= '0;
      prod_q <= '0;
    end else if (adv) begin
      a_q    <= a;
      b_q    <= b;
      sgn_q  <= sgn_in;
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed + random stimulus with a product scoreboard.
// Define WALLACE_SIGNED_EN for both files to exercise the signed mode.
module tb_wallace_mult_pipe;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n, ena, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] prod;
  logic [1:0]    occ;
`ifdef WALLACE_SIGNED_EN
  logic          sgn;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [PW-1:0] sb [$];
  logic [PW-1:0] exp_v;

  logic [W-1:0]  t2a [4] = '{4'd0, 4'd1, 4'd7, 4'd15};
  logic [W-1:0]  t2b [4] = '{4'd0, 4'd15, 4'd9, 4'd1};
  logic [PW-1:0] t2p [4] = '{8'd0, 8'd15, 8'd63, 8'd15};

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef WALLACE_SIGNED_EN
    .sgn      (sgn),
`endif
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .prod     (prod),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    logic signed [PW-1:0] sx, sy;
    if (s) begin
      sx = $signed({{W{x[W-1]}}, x});
      sy = $signed({{W{y[W-1]}}, y});
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  function automatic logic sgn_now();
`ifdef WALLACE_SIGNED_EN
    return sgn;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    a        = x;
    b        = y;
  endtask

  // Scoreboard: push on accept, pop and compare on consume (pipe frozen when ena=0).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && ena) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          check("sb_prod", 32'(prod), 32'(exp_v));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, sgn_now()));
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef WALLACE_SIGNED_EN
    sgn = 1'b0;
`endif
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_prod",      32'(prod),      32'd0);
    check("rst_occ",       32'(occ),       32'd0);
    rst_n = 1'b1;
    step();

    // single 15*15, latency and one-cycle valid
    drive(4'd15, 4'd15); step(); in_valid = 1'b0;
    check("t1_occ",   32'(occ),       32'd1);
    check("t1_ov_e1", 32'(out_valid), 32'd0);
    step(); check("t1_ov_e2", 32'(out_valid), 32'd0);
    step(); check("t1_ov_e3", 32'(out_valid), 32'd1);
    check("t1_prod", 32'(prod), 32'd225);
    step(); check("t1_ov_e4", 32'(out_valid), 32'd0);

    // back-to-back stream
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(t2a[c], t2b[c]); else in_valid = 1'b0;
      step();
      if (c >= 2 && c <= 5) begin
        check("t2_ov",   32'(out_valid), 32'd1);
        check("t2_prod", 32'(prod),      32'(t2p[c-2]));
      end
    end
    check("t2_ov_end", 32'(out_valid), 32'd0);

    // backpressure fill, hold, then release with simultaneous accept at occ=3
    out_ready = 1'b0;
    drive(4'd3, 4'd5); step();
    drive(4'd6, 4'd6); step();
    drive(4'd2, 4'd9); step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("t3_occ",      32'(occ),       32'd3);
      check("t3_in_ready", 32'(in_ready),  32'd0);
      check("t3_ov",       32'(out_valid), 32'd1);
      check("t3_prod",     32'(prod),      32'd15);
      step();
    end
    out_ready = 1'b1;
    drive(4'd9, 4'd9);
    #1;
    check("t3_in_ready_rel", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("t3_occ_full", 32'(occ),  32'd3);
    check("t3_p36",      32'(prod), 32'd36);
    step(); check("t3_p18", 32'(prod), 32'd18);
    step(); check("t3_p81", 32'(prod), 32'd81);
    step(); check("t3_ov_end", 32'(out_valid), 32'd0);
    check("t3_occ_end", 32'(occ), 32'd0);

    // ena low freezes everything
    drive(4'd2, 4'd3); step();
    drive(4'd4, 4'd5); step();
    drive(4'd7, 4'd7); step();
    check("t4_prod6", 32'(prod), 32'd6);
    ena = 1'b0;
    drive(4'd1, 4'd1);
    for (int c = 0; c < 2; c++) begin
      step();
      check("t4_in_ready", 32'(in_ready),  32'd0);
      check("t4_ov",       32'(out_valid), 32'd1);
      check("t4_prod",     32'(prod),      32'd6);
      check("t4_occ",      32'(occ),       32'd3);
    end
    in_valid = 1'b0; ena = 1'b1;
    step(); check("t4_p20", 32'(prod), 32'd20);
    step(); check("t4_p49", 32'(prod), 32'd49);
    step(); check("t4_ov_end", 32'(out_valid), 32'd0);

    // asynchronous reset with two in flight
    drive(4'd3, 4'd3); step();
    drive(4'd4, 4'd4); step();
    in_valid = 1'b0;
    check("t5_occ2", 32'(occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_ov",   32'(out_valid), 32'd0);
    check("t5_prod", 32'(prod),      32'd0);
    check("t5_occ",  32'(occ),       32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_no_stale", 32'(out_valid), 32'd0);
    end
    drive(4'd5, 4'd5); step(); in_valid = 1'b0;
    step(); step();
    check("t5_ov_recover",   32'(out_valid), 32'd1);
    check("t5_prod_recover", 32'(prod),      32'd25);
    step();

`ifdef WALLACE_SIGNED_EN
    sgn = 1'b1;
    drive(4'd8, 4'd8);  step();
    drive(4'd8, 4'd7);  step();
    drive(4'd15, 4'd1); step();
    in_valid = 1'b0;
    check("t6_p64", 32'(prod), 32'h40);
    step(); check("t6_pC8", 32'(prod), 32'hC8);
    step(); check("t6_pFF", 32'(prod), 32'hFF);
    step();
`endif

    // random mixed traffic, scoreboard-checked
    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ena       = ($urandom_range(0, 7) != 0);
`ifdef WALLACE_SIGNED_EN
      sgn       = 1'($urandom_range(0, 1));
`endif
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; ena = 1'b1;
    repeat (6) step();
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_occ",      32'(occ),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
